// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker states and the polynomial tap table used by
// both the generator and the checker.
package prbs_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } prbs_state_e;

    typedef struct packed {
        logic [4:0] a;
        logic [4:0] b;
    } prbs_taps_t;

    function automatic bit prbs_legal(input int order);
        return (order == 7) || (order == 9) || (order == 11) || (order == 15) ||
               (order == 20) || (order == 23) || (order == 31);
    endfunction

    function automatic prbs_taps_t prbs_taps(input int order);
        prbs_taps_t t;
        case (order)
            7:       begin t.a = 5'd7;  t.b = 5'd6;  end
            9:       begin t.a = 5'd9;  t.b = 5'd5;  end
            11:      begin t.a = 5'd11; t.b = 5'd9;  end
            15:      begin t.a = 5'd15; t.b = 5'd14; end
            20:      begin t.a = 5'd20; t.b = 5'd3;  end
            23:      begin t.a = 5'd23; t.b = 5'd18; end
            31:      begin t.a = 5'd31; t.b = 5'd28; end
            default: begin t.a = 5'd7;  t.b = 5'd6;  end
        endcase
        return t;
    endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// Fibonacci PRBS register: predicts the next bit and shifts in either the line
// bit (load) or its own prediction (run).
module prbs_lfsr #(
    parameter int N     = 7,
    parameter int TAP_A = 7,
    parameter int TAP_B = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic adv,
    input  logic load,
    input  logic din,
    output logic pred
);

    logic [N-1:0] r_q;
    logic [N-1:0] r_d;
    logic         x_s;

    assign pred = r_q[TAP_A-1] ^ r_q[TAP_B-1];

    // Next register value: shift in line or prediction when advancing
    always_comb begin
        r_d = r_q;
        x_s = load ? din : pred;
        if (adv) begin
            r_d = {r_q[N-2:0], x_s};
        end else begin
            r_d = r_q;
        end
    end

    // Register state, all-ones after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= {N{1'b1}};
        end else begin
            r_q <= r_d;
        end
    end

endmodule

// File: rtl/prbs_rx.sv
// Self-synchronising PRBS checker: seeds a local LFSR from the line, declares
// lock after SYNC_LEN matches, then counts checked bits and bit errors.
module prbs_rx
    import prbs_pkg::*;
#(
    parameter int PRBS_TYPE     = 7,
    parameter int BIT_CNT_WIDTH = 10,
    parameter int ERR_CNT_WIDTH = 10,
    parameter int SYNC_LEN      = 32,
    parameter int LOSS_LEN      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din_vld,
    input  logic                     din,
    output logic [BIT_CNT_WIDTH-1:0] bit_cnt,
    output logic                     bit_cnt_full,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic                     dout_vld,
    output logic                     dout,
    output logic [9:0]               sync_cnt,
    output logic                     dout_xor
);

    localparam prbs_taps_t TAPS_C = prbs_taps(PRBS_TYPE);
    localparam int         LW     = $clog2(LOSS_LEN + 1);
    localparam logic [9:0]               SYNC_C  = 10'(SYNC_LEN);
    localparam logic [LW-1:0]            LOSS_C  = LW'(LOSS_LEN);
    localparam logic [BIT_CNT_WIDTH-1:0] BIT_MAX = {BIT_CNT_WIDTH{1'b1}};
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = {ERR_CNT_WIDTH{1'b1}};

    generate
        if (!prbs_legal(PRBS_TYPE)) begin : g_bad_type
            $error("prbs_rx: unsupported PRBS_TYPE %0d", PRBS_TYPE);
        end
    endgenerate

    prbs_state_e              state_q, state_d;
    logic [9:0]               sync_q, sync_d;
    logic [LW-1:0]            loss_q, loss_d;
    logic [BIT_CNT_WIDTH-1:0] bit_q, bit_d;
    logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
    logic                     full_q, full_d;
    logic                     dout_q, dout_d;
    logic                     dout_vld_q, dout_vld_d;
    logic                     dout_xor_q, dout_xor_d;
    logic                     pred_s;
    logic                     mism_s;
    logic                     load_s;

    assign load_s = (state_q == SEARCH);
    assign mism_s = din ^ pred_s;

    prbs_lfsr #(
        .N     (PRBS_TYPE),
        .TAP_A (int'(TAPS_C.a)),
        .TAP_B (int'(TAPS_C.b))
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .adv  (din_vld),
        .load (load_s),
        .din  (din),
        .pred (pred_s)
    );

    // Lock FSM, counters and output next-state
    always_comb begin
        state_d    = state_q;
        sync_d     = sync_q;
        loss_d     = loss_q;
        bit_d      = bit_q;
        err_d      = err_q;
        full_d     = full_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        dout_xor_d = 1'b0;
        if (din_vld) begin
            dout_vld_d = 1'b1;
            dout_d     = pred_s;
            dout_xor_d = mism_s;
            case (state_q)
                SEARCH: begin
                    loss_d = LW'(0);
                    if (mism_s) begin
                        sync_d = 10'd0;
                    end else if (sync_q + 10'd1 >= SYNC_C) begin
                        sync_d  = SYNC_C;
                        state_d = LOCKED;
                    end else begin
                        sync_d = sync_q + 10'd1;
                    end
                end
                LOCKED: begin
                    // Once the window closes the counters freeze; the bit that closes it still counts
                    if (!full_q) begin
                        bit_d  = bit_q + BIT_CNT_WIDTH'(1);
                        full_d = (bit_q + BIT_CNT_WIDTH'(1) == BIT_MAX);
                        if (mism_s && (err_q != ERR_MAX)) begin
                            err_d = err_q + ERR_CNT_WIDTH'(1);
                        end else begin
                            err_d = err_q;
                        end
                    end else begin
                        bit_d = bit_q;
                        err_d = err_q;
                    end
                    if (mism_s) begin
                        if (loss_q + LW'(1) >= LOSS_C) begin
                            state_d = SEARCH;
                            sync_d  = 10'd0;
                            loss_d  = LW'(0);
                        end else begin
                            loss_d = loss_q + LW'(1);
                        end
                    end else begin
                        loss_d = LW'(0);
                    end
                end
                default: begin
                    state_d = SEARCH;
                    sync_d  = 10'd0;
                    loss_d  = LW'(0);
                end
            endcase
        end else begin
            dout_vld_d = 1'b0;
            dout_xor_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SEARCH;
            sync_q     <= 10'd0;
            loss_q     <= LW'(0);
            bit_q      <= BIT_CNT_WIDTH'(0);
            err_q      <= ERR_CNT_WIDTH'(0);
            full_q     <= 1'b0;
            dout_q     <= 1'b0;
            dout_vld_q <= 1'b0;
            dout_xor_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            loss_q     <= loss_d;
            bit_q      <= bit_d;
            err_q      <= err_d;
            full_q     <= full_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            dout_xor_q <= dout_xor_d;
        end
    end

    assign bit_cnt      = bit_q;
    assign bit_cnt_full = full_q;
    assign err_cnt      = err_q;
    assign sync_cnt     = sync_q;
    assign dout         = dout_q;
    assign dout_vld     = dout_vld_q;
    assign dout_xor     = dout_xor_q;

endmodule

// File: tb/tb_prbs_rx.sv
// Directed bench for prbs_rx: four lanes (PRBS7/15/23/31) fed from bench-side
// generators and checked against a bench model plus hand-derived constants.
module tb_prbs_rx;

    localparam int L = 4;
    localparam int NT[L] = '{7, 15, 23, 31};
    localparam int TA[L] = '{7, 15, 23, 31};
    localparam int TB[L] = '{6, 14, 18, 28};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         din_vld = 1'b0;
    logic [L-1:0] din = '0;

    logic [9:0] bit_cnt_s  [L];
    logic [9:0] err_cnt_s  [L];
    logic [9:0] sync_cnt_s [L];
    logic       full_s     [L];
    logic       dout_vld_s [L];
    logic       dout_s     [L];
    logic       dout_xor_s [L];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] t_r [L];
    logic [31:0] m_r [L];
    int          m_sync [L], m_bit [L], m_err [L], m_loss [L];
    logic        m_state [L], m_full [L], m_dout [L], m_xor [L], m_vo [L];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < L; g++) begin : g_dut
            prbs_rx #(.PRBS_TYPE((g == 0) ? 7 : (g == 1) ? 15 : (g == 2) ? 23 : 31)) u_dut (
                .clk          (clk),
                .rst          (rst),
                .din_vld      (din_vld),
                .din          (din[g]),
                .bit_cnt      (bit_cnt_s[g]),
                .bit_cnt_full (full_s[g]),
                .err_cnt      (err_cnt_s[g]),
                .dout_vld     (dout_vld_s[g]),
                .dout         (dout_s[g]),
                .sync_cnt     (sync_cnt_s[g]),
                .dout_xor     (dout_xor_s[g])
            );
        end
    endgenerate

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input int l);
        return (32'd1 << NT[l]) - 32'd1;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < L; l++) begin
            m_r[l] = lane_mask(l);
            m_sync[l] = 0; m_bit[l] = 0; m_err[l] = 0; m_loss[l] = 0;
            m_state[l] = 1'b0; m_full[l] = 1'b0; m_dout[l] = 1'b0;
            m_xor[l] = 1'b0; m_vo[l] = 1'b0;
        end
    endtask

    task automatic model_step(input logic vld, input logic [L-1:0] d);
        logic pred, mism, x;
        for (int l = 0; l < L; l++) begin
            if (vld) begin
                pred = m_r[l][TA[l]-1] ^ m_r[l][TB[l]-1];
                mism = d[l] ^ pred;
                m_dout[l] = pred; m_xor[l] = mism; m_vo[l] = 1'b1;
                if (!m_state[l]) begin
                    x = d[l];
                    m_loss[l] = 0;
                    if (mism) m_sync[l] = 0;
                    else begin
                        m_sync[l]++;
                        if (m_sync[l] == 32) m_state[l] = 1'b1;
                    end
                end else begin
                    x = pred;
                    if (!m_full[l]) begin
                        m_bit[l]++;
                        if (mism && m_err[l] < 1023) m_err[l]++;
                        if (m_bit[l] == 1023) m_full[l] = 1'b1;
                    end
                    if (mism) begin
                        m_loss[l]++;
                        if (m_loss[l] == 8) begin
                            m_state[l] = 1'b0; m_sync[l] = 0; m_loss[l] = 0;
                        end
                    end else m_loss[l] = 0;
                end
                m_r[l] = ((m_r[l] << 1) | {31'd0, x}) & lane_mask(l);
            end else begin
                m_vo[l] = 1'b0; m_xor[l] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        for (int l = 0; l < L; l++) begin
            check_eq($sformatf("bit_cnt[%0d]", l), {22'd0, bit_cnt_s[l]}, m_bit[l]);
            check_eq($sformatf("err_cnt[%0d]", l), {22'd0, err_cnt_s[l]}, m_err[l]);
            check_eq($sformatf("sync_cnt[%0d]", l), {22'd0, sync_cnt_s[l]}, m_sync[l]);
            check_eq($sformatf("full[%0d]", l), {31'd0, full_s[l]}, {31'd0, m_full[l]});
            check_eq($sformatf("dout_vld[%0d]", l), {31'd0, dout_vld_s[l]}, {31'd0, m_vo[l]});
            check_eq($sformatf("dout[%0d]", l), {31'd0, dout_s[l]}, {31'd0, m_dout[l]});
            check_eq($sformatf("dout_xor[%0d]", l), {31'd0, dout_xor_s[l]}, {31'd0, m_xor[l]});
        end
    endtask

    // One clock: generate the clean bit per lane, apply flips, drive, then check after the edge
    task automatic step(input logic vld, input logic [L-1:0] flip);
        logic [L-1:0] d;
        logic b;
        d = '0;
        for (int l = 0; l < L; l++) begin
            if (vld) begin
                b = t_r[l][TA[l]-1] ^ t_r[l][TB[l]-1];
                t_r[l] = ((t_r[l] << 1) | {31'd0, b}) & lane_mask(l);
                d[l] = b ^ flip[l];
            end else begin
                d[l] = 1'b0;
            end
        end
        @(negedge clk);
        din_vld = vld;
        din = d;
        @(posedge clk);
        #1;
        model_step(vld, d);
        compare_all();
    endtask

    task automatic do_reset(input logic reseed_tx);
        @(negedge clk);
        #2;
        rst = 1'b0;
        din_vld = 1'b0;
        #1;
        for (int l = 0; l < L; l++) begin
            check_eq($sformatf("rst_bit_cnt[%0d]", l), {22'd0, bit_cnt_s[l]}, 32'd0);
            check_eq($sformatf("rst_err_cnt[%0d]", l), {22'd0, err_cnt_s[l]}, 32'd0);
            check_eq($sformatf("rst_sync_cnt[%0d]", l), {22'd0, sync_cnt_s[l]}, 32'd0);
            check_eq($sformatf("rst_outs[%0d]", l),
                     {28'd0, full_s[l], dout_vld_s[l], dout_s[l], dout_xor_s[l]}, 32'd0);
        end
        model_reset();
        if (reseed_tx) begin
            for (int l = 0; l < L; l++) t_r[l] = lane_mask(l);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int guard;
        logic all_full;
        for (int l = 0; l < L; l++) t_r[l] = lane_mask(l);
        model_reset();
        #12;
        do_reset(1'b1);

        // Clean stream from the same all-ones seed: every bit matches, lock on the 32nd
        for (int k = 1; k <= 48; k++) begin
            step(1'b1, 4'h0);
            if (k <= 32) check_eq($sformatf("t1_sync_k%0d", k), {22'd0, sync_cnt_s[0]}, k);
            else check_eq($sformatf("t1_dout_eq_din_k%0d", k), {31'd0, dout_s[0]}, {31'd0, din[0]});
        end
        check_eq("t1_bit_cnt", {22'd0, bit_cnt_s[3]}, 32'd16);
        check_eq("t1_err_cnt", {22'd0, err_cnt_s[0]}, 32'd0);

        // Single flipped bit while locked
        step(1'b1, 4'hF);
        check_eq("t2_xor_pulse", {31'd0, dout_xor_s[0]}, 32'd1);
        check_eq("t2_err_cnt", {22'd0, err_cnt_s[1]}, 32'd1);
        step(1'b1, 4'h0);
        check_eq("t2_xor_clear", {31'd0, dout_xor_s[0]}, 32'd0);
        check_eq("t2_still_locked", {22'd0, sync_cnt_s[2]}, 32'd32);

        // Eight consecutive inverted bits drop lock; LFSR stayed aligned so relock takes 32
        for (int k = 0; k < 8; k++) step(1'b1, 4'hF);
        check_eq("t5_err_cnt", {22'd0, err_cnt_s[0]}, 32'd9);
        check_eq("t5_sync_zero", {22'd0, sync_cnt_s[3]}, 32'd0);
        for (int k = 0; k < 32; k++) step(1'b1, 4'h0);
        check_eq("t5_relock", {22'd0, sync_cnt_s[0]}, 32'd32);
        check_eq("t5_err_kept", {22'd0, err_cnt_s[2]}, 32'd9);

        // Mid-stream reset with the generators left running; relock within 32+N bits
        do_reset(1'b0);
        for (int k = 0; k < 100; k++) step(1'b1, 4'h0);
        for (int l = 0; l < L; l++) begin
            check_eq($sformatf("t6_relock[%0d]", l), {22'd0, sync_cnt_s[l]}, 32'd32);
            check_eq($sformatf("t6_err[%0d]", l), {22'd0, err_cnt_s[l]}, 32'd0);
        end

        // din_vld toggling every clock from a fresh seed
        do_reset(1'b1);
        for (int k = 1; k <= 80; k++) begin
            step(1'b1, 4'h0);
            step(1'b0, 4'h0);
            if (k == 20) check_eq("t3_sync_half", {22'd0, sync_cnt_s[0]}, 32'd20);
        end
        check_eq("t3_bit_cnt", {22'd0, bit_cnt_s[0]}, 32'd48);
        check_eq("t3_err_cnt", {22'd0, err_cnt_s[3]}, 32'd0);

        // Fill the measurement window, then inject errors that must not count
        guard = 0;
        all_full = 1'b0;
        while (!all_full && guard < 4000) begin
            step(1'b1, 4'h0);
            guard++;
            all_full = m_full[0] & m_full[1] & m_full[2] & m_full[3];
        end
        for (int l = 0; l < L; l++) begin
            check_eq($sformatf("t4_full[%0d]", l), {31'd0, full_s[l]}, 32'd1);
            check_eq($sformatf("t4_bit_cnt[%0d]", l), {22'd0, bit_cnt_s[l]}, 32'd1023);
        end
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 4'hF);
            step(1'b1, 4'h0);
        end
        check_eq("t4_err_frozen", {22'd0, err_cnt_s[0]}, 32'd0);
        check_eq("t4_bit_frozen", {22'd0, bit_cnt_s[1]}, 32'd1023);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
